interrupt_dispatcher: RTL
=========================

Name: interrupt_dispatcher

Overview:
Sits directly downstream of the old/new interrupt pending register and consumes its 8-bit pending vector. It masks the vector, picks one source by priority and raises a request/acknowledge handshake with the processor control unit. It supplies the handler vector address, then returns a 4-bit clear code upstream so the serviced pending bit is dropped. It holds off further dispatch until the handler signals completion.

Parameters:
VEC_BASE, 16'h0100, handler address for source 0
VEC_STRIDE, 16'h0010, address spacing between consecutive source handlers

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST_N  in  1  asynchronous, active-low reset
PENDING  in  8  pending-interrupt vector from upstream register; bit i = source i
MASK  in  8  per-source enable; 1 = source may be dispatched
INT_EN  in  1  global interrupt enable from control unit
INT_ACK  in  1  control unit accepts the current request
INT_DONE  in  1  one-cycle pulse: handler finished (return-from-interrupt)
INT_REQ  out  1  interrupt request to control unit
INT_ID  out  3  index of the dispatched source
INT_VECTOR  out  16  handler address = VEC_BASE + INT_ID*VEC_STRIDE, mod 2^16
CLR_OUT  out  4  clear code to upstream: bit3 = clear strobe, bits[2:0] = index; 4'h0 = no clear
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset (async, RST_N low): state IDLE; INT_REQ=0, INT_ID=0, INT_VECTOR=VEC_BASE, CLR_OUT=0, BUSY=0. Reset mid-operation abandons the dispatch. The upstream pending bit is not cleared.
- Eligible vector E = PENDING & MASK, gated by INT_EN. Fixed priority: lowest set index wins.
- IDLE: if E≠0 at an edge, latch the winner into INT_ID and INT_VECTOR, then go to REQ. INT_REQ is high from the next cycle, giving 1-cycle latency from an eligible PENDING bit to INT_REQ.
- REQ: INT_REQ=1. INT_ID and INT_VECTOR are frozen; later PENDING, MASK or INT_EN changes are ignored because the dispatch is committed. INT_ACK sampled high -> CLEAR.
- CLEAR (exactly one cycle): INT_REQ=0, CLR_OUT={1'b1, INT_ID}, then go to SERVICE. CLR_OUT is 4'h0 in every other state.
- SERVICE: waits for INT_DONE; on INT_DONE -> IDLE.
- INT_ACK is ignored outside REQ. INT_DONE is ignored outside SERVICE.
- Source reasserted upstream while its own dispatch is in SERVICE: it stays pending and is re-dispatched after return to IDLE.
- Back-to-back: the minimum gap from INT_DONE to the next INT_REQ is 1 cycle (IDLE evaluation).
- INT_VECTOR arithmetic is 16-bit unsigned with wrap-around; no saturation.

Optional Feature:
ROUND_ROBIN_EN
- Defined: a 3-bit priority pointer (reset 0) makes the search start at the pointer and wrap 7->0. On INT_DONE the pointer becomes INT_ID+1 mod 8.
- Undefined: fixed lowest-index priority as above; the pointer logic is absent.

Decomposition:
- Shared package intr_pkg:
  - state encoding typedef (IDLE, REQ, CLEAR, SERVICE)
  - N_SRC=8 and ID_W=3 constants
  - clear-code field positions (strobe bit 3, index bits 2:0)
- Sub-module intr_prio_sel: combinational 8-to-3 priority picker with a start-pointer input and a valid output. Tie the pointer to 0 when ROUND_ROBIN_EN is undefined.

Test Plan:
- Reset: hold RST_N=0 with PENDING=8'hFF -> INT_REQ=0, CLR_OUT=4'h0, INT_VECTOR=16'h0100, BUSY=0.
- Basic dispatch: PENDING=8'h7F, MASK=8'hFF, INT_EN=1 -> next cycle INT_REQ=1, INT_ID=0, INT_VECTOR=16'h0100. INT_ACK -> CLR_OUT=4'h8 for one cycle. INT_DONE -> IDLE.
- Masking: PENDING=8'h24, MASK=8'hF0 -> INT_ID=5, INT_VECTOR=16'h0150. Ack -> CLR_OUT=4'hD.
- Commitment: in REQ with INT_ID=2, change PENDING to 8'h01 and drop INT_EN -> INT_ID stays 2. Ack -> CLR_OUT=4'hA.
- Gating: INT_EN=0 with PENDING=8'hFF -> INT_REQ stays 0 for 20 cycles. Stray INT_ACK and INT_DONE pulses cause no state change.
- Reset mid-SERVICE -> outputs return to reset values immediately, then re-dispatch of the still-pending source after RST_N rises. With ROUND_ROBIN_EN and PENDING=8'h03: dispatch 0 then 1 then 0.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt dispatcher: FSM states, source
// count/width, clear-code field positions and the handler address helper.
package intr_pkg;

  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  localparam int CLR_W       = 4;
  localparam int CLR_STB_BIT = 3;
  localparam int CLR_IDX_MSB = 2;
  localparam int CLR_IDX_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_CLEAR   = 2'd2,
    ST_SERVICE = 2'd3
  } state_t;

  // Handler address, 16-bit unsigned with natural wrap-around.
  function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                           input logic [15:0] stride,
                                           input logic [ID_W-1:0] id);
    return base + stride * {{(16-ID_W){1'b0}}, id};
  endfunction

endpackage

// File: rtl/intr_prio_sel.sv
// Combinational 8-to-3 priority picker: first set bit at or after ptr, wrapping 7->0.
// Zero latency; valid is low when no request bit is set.
module intr_prio_sel
  import intr_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  logic [ID_W-1:0] idx;

  always_comb begin
    valid = 1'b0;
    id    = '0;
    idx   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      idx = ptr + ID_W'(i);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        id    = idx;
      end
    end
  end

endmodule

// File: rtl/interrupt_dispatcher.sv
// Masks pending interrupts, picks one, runs REQ/ACK then a one-cycle clear, holds until INT_DONE.
// 1 cycle from eligible PENDING to INT_REQ; optional ROUND_ROBIN_EN rotates the search start.
module interrupt_dispatcher
  import intr_pkg::*;
#(
  parameter logic [15:0] VEC_BASE   = 16'h0100,
  parameter logic [15:0] VEC_STRIDE = 16'h0010
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_SRC-1:0] PENDING,
  input  logic [N_SRC-1:0] MASK,
  input  logic             INT_EN,
  input  logic             INT_ACK,
  input  logic             INT_DONE,
  output logic             INT_REQ,
  output logic [ID_W-1:0]  INT_ID,
  output logic [15:0]      INT_VECTOR,
  output logic [CLR_W-1:0] CLR_OUT,
  output logic             BUSY
);

  state_t          state_q, state_d;
  logic [ID_W-1:0] id_q;
  logic [15:0]     vec_q;
  logic [N_SRC-1:0] eligible;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] sel_id;
  logic            sel_vld;
  logic            latch_en;

  assign eligible = PENDING & MASK & {N_SRC{INT_EN}};

`ifdef ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr_q;

  // Search resumes just past the source that most recently completed.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q <= '0;
    end else if (state_q == ST_SERVICE && INT_DONE) begin
      ptr_q <= id_q + ID_W'(1);
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  intr_prio_sel u_prio_sel (
    .req   (eligible),
    .ptr   (ptr),
    .id    (sel_id),
    .valid (sel_vld)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      vec_q   <= VEC_BASE;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        id_q  <= sel_id;
        vec_q <= vec_addr(VEC_BASE, VEC_STRIDE, sel_id);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    INT_REQ  = 1'b0;
    CLR_OUT  = '0;
    BUSY     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        BUSY = 1'b0;
        if (sel_vld) begin
          latch_en = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        INT_REQ = 1'b1;
        if (INT_ACK) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        CLR_OUT[CLR_STB_BIT]             = 1'b1;
        CLR_OUT[CLR_IDX_MSB:CLR_IDX_LSB] = id_q;
        state_d                          = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (INT_DONE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign INT_ID     = id_q;
  assign INT_VECTOR = vec_q;

endmodule
